// File: rtl/mult_seq_param.sv
// mult_seq_param: self-sequenced, parametrised A_W x B_W multiplier.
// One A_CHUNK x B_CHUNK partial product is accumulated per RUN cycle; signed
// operands are handled as magnitudes with a final two's-complement fix-up.
//
// Ports:
//   clk        clock, all state on rising edge
//   reset      asynchronous active-low reset
//   start      operation request, sampled only in IDLE
//   is_signed  1 = two's-complement operands, sampled with start
//   a, b       operands, sampled with start
//   busy       high while RUN or FIX
//   done       one-cycle completion pulse
//   product    result register, valid with done, held until next start
module mult_seq_param #(
  parameter int A_W     = 32,
  parameter int B_W     = 32,
  parameter int A_CHUNK = 8,
  parameter int B_CHUNK = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [A_W-1:0]       a,
  input  logic [B_W-1:0]       b,
  output logic                 busy,
  output logic                 done,
  output logic [A_W+B_W-1:0]   product
);

  localparam int NA   = A_W / A_CHUNK;
  localparam int NB   = B_W / B_CHUNK;
  localparam int P_W  = A_W + B_W;
  localparam int PP_W = A_CHUNK + B_CHUNK;
  localparam int IW   = (NA > 1) ? $clog2(NA) : 1;
  localparam int JW   = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [A_W-1:0]     r_a_mag;
  logic [B_W-1:0]     r_b_mag;
  logic               r_neg;
  logic [IW-1:0]      r_i;
  logic [JW-1:0]      r_j;
  logic [P_W-1:0]     r_product;

  logic               w_a_neg;
  logic               w_b_neg;
  logic [A_W-1:0]     w_a_mag_in;
  logic [B_W-1:0]     w_b_mag_in;
  int                 w_a_off;
  int                 w_b_off;
  logic [A_CHUNK-1:0] w_a_slice;
  logic [B_CHUNK-1:0] w_b_slice;
  logic [PP_W-1:0]    w_pp;
  logic [P_W-1:0]     w_term;
  logic               w_last;

  // Operand magnitudes; the most-negative value maps to 2^(W-1) unsigned.
  always_comb begin
    w_a_neg    = is_signed & a[A_W-1];
    w_b_neg    = is_signed & b[B_W-1];
    w_a_mag_in = w_a_neg ? (~a + A_W'(1)) : a;
    w_b_mag_in = w_b_neg ? (~b + B_W'(1)) : b;
  end

  // Current partial product, zero-extended then shifted into place.
  always_comb begin
    w_a_off   = int'(r_i) * A_CHUNK;
    w_b_off   = int'(r_j) * B_CHUNK;
    w_a_slice = r_a_mag[w_a_off +: A_CHUNK];
    w_b_slice = r_b_mag[w_b_off +: B_CHUNK];
    w_pp      = PP_W'(w_a_slice) * PP_W'(w_b_slice);
    w_term    = P_W'(w_pp) << (w_a_off + w_b_off);
    w_last    = (r_i == IW'(NA - 1)) && (r_j == JW'(NB - 1));
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (w_last) w_state_nxt = r_neg ? S_FIX : S_DONE;
      S_FIX:   w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy = (r_state == S_RUN) || (r_state == S_FIX);
    done = (r_state == S_DONE);
  end

  assign product = r_product;

  // Datapath: operand capture, accumulation, sign fix-up
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a_mag   <= '0;
      r_b_mag   <= '0;
      r_neg     <= 1'b0;
      r_i       <= '0;
      r_j       <= '0;
      r_product <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a_mag   <= w_a_mag_in;
            r_b_mag   <= w_b_mag_in;
            r_neg     <= is_signed & (a[A_W-1] ^ b[B_W-1]);
            r_i       <= '0;
            r_j       <= '0;
            r_product <= '0;
          end
        end
        S_RUN: begin
          r_product <= r_product + w_term;
          // i runs fastest; both indices return to 0 after the last slice pair
          if (r_i == IW'(NA - 1)) begin
            r_i <= '0;
            r_j <= w_last ? '0 : r_j + JW'(1);
          end else begin
            r_i <= r_i + IW'(1);
          end
        end
        S_FIX: begin
          r_product <= ~r_product + P_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq_param.sv
// Self-checking bench for mult_seq_param: directed vector table, randomized
// operations against an arithmetic reference, and hand-written sequences for
// start-while-busy and asynchronous reset mid-operation. A second instance
// covers the 16x16 / 8x8 parameter variant.
module tb_mult_seq_param;

  logic        clk = 1'b0;
  logic        reset;

  logic        start, is_signed;
  logic [31:0] a, b;
  logic        busy, done;
  logic [63:0] product;

  logic        v_start, v_is_signed;
  logic [15:0] v_a, v_b;
  logic        v_busy, v_done;
  logic [31:0] v_product;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mult_seq_param dut (
    .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
    .a(a), .b(b), .busy(busy), .done(done), .product(product)
  );

  mult_seq_param #(.A_W(16), .B_W(16), .A_CHUNK(8), .B_CHUNK(8)) dut_v (
    .clk(clk), .reset(reset), .start(v_start), .is_signed(v_is_signed),
    .a(v_a), .b(v_b), .busy(v_busy), .done(v_done), .product(v_product)
  );

  typedef struct {
    bit          sgn;
    logic [31:0] x;
    logic [31:0] y;
    logic [63:0] exp_p;
    int          exp_lat;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain integer multiplication modulo 2^64.
  function automatic logic [63:0] model64(input bit sgn, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy;
    if (sgn) begin
      sx = $signed(x);
      sy = $signed(y);
      return 64'(sx * sy);
    end
    return {32'h0, x} * {32'h0, y};
  endfunction

  function automatic logic [31:0] model32(input bit sgn, input logic [15:0] x, input logic [15:0] y);
    int sx, sy;
    if (sgn) begin
      sx = $signed(x);
      sy = $signed(y);
      return 32'(sx * sy);
    end
    return {16'h0, x} * {16'h0, y};
  endfunction

  // Edges from the start edge until done is seen: N, plus one when the sign fix runs.
  function automatic int lat_of(input int n, input bit sgn, input bit msb_a, input bit msb_b);
    return n + ((sgn && (msb_a != msb_b)) ? 1 : 0);
  endfunction

  // Called #1 after a rising edge with the DUT in IDLE.
  task automatic run_op(input bit sgn, input logic [31:0] x, input logic [31:0] y,
                        input logic [63:0] exp_p, input int exp_lat, input string tag,
                        input bit hold);
    int lat;
    bit busy_ok;
    int extra_done;
    start = 1'b1; is_signed = sgn; a = x; b = y;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    a = $urandom; b = $urandom; is_signed = 1'($urandom_range(0, 1));
    lat = -1;
    busy_ok = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (k == 3) a = $urandom;
      if (done) begin
        lat = k;
        break;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, " product"}, product, exp_p);
    chk({tag, " busy during run"}, 64'(busy_ok), 64'd1);
    chk({tag, " busy at done"}, 64'(busy), 64'd0);
    start = 1'b0;
    @(posedge clk); #1;
    chk({tag, " done pulse width"}, 64'(done), 64'd0);
    chk({tag, " product hold"}, product, exp_p);
    if (hold) begin
      extra_done = 0;
      for (int k = 0; k < 4; k++) begin
        @(posedge clk); #1;
        if (done || busy) extra_done++;
      end
      chk({tag, " no second op"}, 64'(extra_done), 64'd0);
    end
  endtask

  task automatic run_op_v(input bit sgn, input logic [15:0] x, input logic [15:0] y,
                          input logic [31:0] exp_p, input int exp_lat, input string tag);
    int lat;
    v_start = 1'b1; v_is_signed = sgn; v_a = x; v_b = y;
    @(posedge clk); #1;
    v_start = 1'b0;
    v_a = 16'($urandom); v_b = 16'($urandom);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (v_done) begin
        lat = k;
        break;
      end
    end
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, " product"}, 64'(v_product), 64'(exp_p));
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 4))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  vec_t vecs[9];

  initial begin
    vecs[0] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 8};
    vecs[1] = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0005, 64'hFFFF_FFFF_FFFF_FFFB, 9};
    vecs[2] = '{1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 8};
    vecs[3] = '{1'b0, 32'h0000_0000, 32'h1234_5678, 64'h0, 8};
    vecs[4] = '{1'b1, 32'h0000_0000, 32'h8000_0000, 64'h0, 9};
    vecs[5] = '{1'b0, 32'h8000_0000, 32'h0000_0002, 64'h0000_0001_0000_0000, 8};
    vecs[6] = '{1'b1, 32'h8000_0000, 32'h0000_0001, 64'hFFFF_FFFF_8000_0000, 9};
    vecs[7] = '{1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 64'd6, 8};
    vecs[8] = '{1'b0, 32'h0000_0003, 32'h0000_0007, 64'd21, 8};

    reset = 1'b0;
    start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
    v_start = 1'b0; v_is_signed = 1'b0; v_a = '0; v_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset product", product, 64'h0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i])
      run_op(vecs[i].sgn, vecs[i].x, vecs[i].y, vecs[i].exp_p, vecs[i].exp_lat,
             $sformatf("vec%0d", i), 1'b0);

    // start held high and a changed mid-run: exactly one operation
    run_op(1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 64'h0B00_EA4E_242D_2080, 8, "start-held", 1'b1);

    for (int n = 0; n < 40; n++) begin
      logic [31:0] x, y;
      bit sg;
      sg = 1'($urandom_range(0, 1));
      x = pick32();
      y = pick32();
      run_op(sg, x, y, model64(sg, x, y), lat_of(8, sg, x[31], y[31]),
             $sformatf("rand%0d", n), 1'b0);
    end

    // asynchronous reset during RUN cycle 4
    start = 1'b1; is_signed = 1'b0; a = 32'h1234_5678; b = 32'h9ABC_DEF0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("midreset product", product, 64'h0);
    chk("midreset busy", 64'(busy), 64'd0);
    chk("midreset done", 64'(done), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    begin
      int seen;
      seen = 0;
      for (int k = 0; k < 10; k++) begin
        @(posedge clk); #1;
        if (done || busy) seen++;
      end
      chk("midreset no result", 64'(seen), 64'd0);
    end
    run_op(1'b0, 32'd3, 32'd7, 64'd21, 8, "post-reset", 1'b0);

    // 16x16 variant with 8x8 chunks (N = 4)
    run_op_v(1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 4, "var-max");
    for (int n = 0; n < 20; n++) begin
      logic [15:0] x, y;
      bit sg;
      sg = 1'($urandom_range(0, 1));
      x = 16'($urandom);
      y = (n % 5 == 0) ? 16'h8000 : 16'($urandom);
      run_op_v(sg, x, y, model32(sg, x, y), lat_of(4, sg, x[15], y[15]),
               $sformatf("var-rand%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
